// File: rtl/dl_rf_wr_arbiter.sv
// Round-robin arbiter sharing one register-file write port among NUM_REQ writeback sources.
// Latency 1 (registered write, one-hot decoded enable); stall blocks every grant and freezes rr_ptr.
// Optional macro DL_RF_WR_ARB_X0_FILTER_EN: accepted writes to x0 never raise wr_valid/wr_en.
module dl_rf_wr_arbiter #(
  parameter int  NUM_REQ    = 2,
  parameter int  DATA_WIDTH = 32,
  localparam int ADDR_WIDTH = $clog2(32),
  localparam int IDW        = $clog2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          stall,
  input  logic [NUM_REQ-1:0]            req_valid,
  output logic [NUM_REQ-1:0]            req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  output logic                          wr_valid,
  output logic [ADDR_WIDTH-1:0]         wr_addr,
  output logic [DATA_WIDTH-1:0]         wr_data,
  output logic [31:0]                   wr_en,
  output logic [IDW-1:0]                grant_id
);

  logic [IDW-1:0]        r_rr_ptr;
  logic                  r_wr_valid;
  logic [ADDR_WIDTH-1:0] r_wr_addr;
  logic [DATA_WIDTH-1:0] r_wr_data;
  logic [31:0]           r_wr_en;
  logic [IDW-1:0]        r_grant_id;

  logic                  w_found;
  logic [IDW-1:0]        w_winner;
  logic [IDW:0]          w_idx;
  logic                  w_grant;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_present;
  logic [IDW-1:0]        w_ptr_next;

  // Scan from rr_ptr upward with wrap; w_idx is one bit wider so the wrap compare is exact.
  always_comb begin
    w_found  = 1'b0;
    w_winner = '0;
    w_idx    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = {1'b0, r_rr_ptr} + (IDW+1)'(k);
      if (w_idx >= (IDW+1)'(NUM_REQ)) begin
        w_idx = w_idx - (IDW+1)'(NUM_REQ);
      end
      for (int i = 0; i < NUM_REQ; i++) begin
        if (!w_found && (w_idx == (IDW+1)'(i)) && req_valid[i]) begin
          w_found  = 1'b1;
          w_winner = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IDW'(i)) begin
        w_sel_addr = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
        w_sel_data = req_data[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign w_grant    = w_found & ~stall & ~rst;
  assign req_ready  = w_grant ? (NUM_REQ'(1) << w_winner) : '0;
  assign w_ptr_next = (w_winner == IDW'(NUM_REQ-1)) ? '0 : w_winner + IDW'(1);

`ifdef DL_RF_WR_ARB_X0_FILTER_EN
  assign w_present = (w_sel_addr != '0);
`else
  assign w_present = 1'b1;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_rr_ptr   <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_data  <= '0;
      r_wr_en    <= '0;
      r_grant_id <= '0;
    end else if (w_grant) begin
      r_rr_ptr   <= w_ptr_next;
      r_wr_valid <= w_present;
      r_wr_addr  <= w_sel_addr;
      r_wr_data  <= w_sel_data;
      r_wr_en    <= w_present ? (32'd1 << w_sel_addr) : 32'd0;
      r_grant_id <= w_winner;
    end else begin
      r_wr_valid <= 1'b0;
      r_wr_en    <= '0;
    end
  end

  assign wr_valid = r_wr_valid;
  assign wr_addr  = r_wr_addr;
  assign wr_data  = r_wr_data;
  assign wr_en    = r_wr_en;
  assign grant_id = r_grant_id;

endmodule
